lcd_text_driver: RTL and testbench
==================================

LCD_TEXT_DRIVER -- requirements
Module: lcd_text_driver

Interface
REQ-001 CLK_HZ, 50_000_000, system clock frequency; sets the 1 us tick divider (CLK_HZ/1_000_000, integer, at least 2).
REQ-002 FIFO_DEPTH, 32, write-FIFO entries; power of two, 4..256.
REQ-003 COLS, 16, visible characters per row, 1..40.
REQ-004 ROWS, 2, display rows, 1 or 2 (row bases 0x00 and 0x40).
REQ-005 BUSY_TO_US, 2000, busy-flag poll timeout in microseconds.
REQ-006 clk  in  1  single system clock; every register is clocked on the rising edge.
REQ-007 RST  in  1  reset, synchronous, active-high.
REQ-008 WR_EN  in  1  pushes DATA_IN into the FIFO on a clk edge when FULL=0.
REQ-009 DATA_IN  in  9  bit8 is RS (1=character, 0=command); bits7:0 are the byte.
REQ-010 BF  in  1  LCD busy flag (DB7 read-back).
REQ-011 FULL / EMPTY  out  1 each  FIFO status, registered.
REQ-012 READY  out  1  high once power-up initialisation is complete.
REQ-013 OVERFLOW / TIMEOUT  out  1 each  sticky error flags, cleared only by RST.
REQ-014 LCD_E, LCD_RS, LCD_RW  out  1 each  registered LCD strobes.
REQ-015 LCD_DB  out  8  registered LCD data bus.

Function
REQ-016 Timing shall advance only on the 1 us tick; each LCD bus phase (setup, E high, E low) lasts exactly one tick.
REQ-017 The power-up sequence shall run in this order:
  - wait 15000 ticks;
  - write 0x3C with RS=0, RW=0 three times, separated by 4500, 4500 and 150 tick waits, with no BF polling;
  - issue 0x3C, 0x06, 0x0C, 0x01, each followed by a BF poll;
  - assert READY.
REQ-018 The FIFO shall accept writes during power-up; entries are drained only after READY=1.
REQ-019 A write with FULL=1 shall be dropped and shall set OVERFLOW; the FIFO contents stay unchanged.
REQ-020 A write and a read in the same cycle shall both take effect; the occupancy count is unchanged.
REQ-021 Pointers shall wrap modulo FIFO_DEPTH.
REQ-022 FSM states: PWR_WAIT, PWR_STROBE, CFG, IDLE, FETCH, SETUP, E_HI, E_LO, POLL_SETUP, POLL_E_HI, POLL_SAMPLE, POLL_E_LO, WRAP.
REQ-023 IDLE -> FETCH when READY=1 and EMPTY=0; FETCH pops one entry and drives LCD_RS=bit8, LCD_RW=0, LCD_DB=bits7:0.
REQ-024 After E_LO the FSM shall enter the poll: LCD_RW=1, LCD_RS=0; E high; sample BF in POLL_SAMPLE; E low.
REQ-025 The poll shall repeat while BF=1; on BF=0 it exits to WRAP check or IDLE.
REQ-026 If a poll exceeds BUSY_TO_US ticks, the FSM shall set TIMEOUT and continue as if BF=0.
REQ-027 Cursor tracking, row 0..ROWS-1 and col 0..COLS-1:
  - a character write increments col;
  - command 0x01 or 0x02 sets row=0, col=0;
  - a command with bit7=1 loads row=(addr>=0x40) and col=addr&0x3F, saturated to COLS-1.
REQ-028 When a character write makes col reach COLS, the FSM shall enter WRAP: row=(row+1) mod ROWS, col=0, then issue command 0x80|row_base with a full BF poll before returning to IDLE.
REQ-029 LCD_DB shall hold its last value while LCD_RW=1; only the top level tristates the bus.

Reset
REQ-030 While RST=1 the block shall hold:
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0x00;
  - READY=0, OVERFLOW=0, TIMEOUT=0;
  - FIFO empty (EMPTY=1, FULL=0);
  - row=0, col=0, tick divider=0, FSM=PWR_WAIT.
REQ-031 RST asserted mid-transaction, including with E high, shall drive E low on the next edge and restart the full power-up sequence after release.

Structure
REQ-032 Package lcd_pkg shall hold:
  - the FSM state encoding;
  - the constants for the command bytes (0x3C, 0x06, 0x0C, 0x01, 0x02, 0x80);
  - the row base addresses;
  - the power-up wait counts.
REQ-033 The FIFO shall be a separate sub-module, lcd_cmd_fifo, parametrised by FIFO_DEPTH with a 9-bit width.

Verification
REQ-034 Power-up: release RST with BF tied 0 -> three 0x3C strobes about 15 ms, 19.5 ms and 24 ms after release; then 0x3C, 0x06, 0x0C, 0x01; then READY=1.
REQ-035 Wrap: COLS=16, ROWS=2, push 17 characters 'A'..'Q' -> 16 character writes, then command 0xC0, then 'Q' with RS=1.
REQ-036 Second wrap: push a further 16 characters -> command 0x80 is issued after the 32nd character.
REQ-037 Overflow: with READY=0, push 33 entries into depth 32 -> FULL=1 after 32 pushes, OVERFLOW=1, first 32 entries drained in order after READY.
REQ-038 Busy: hold BF=1 for 300 us after a write -> E pulses repeat, the next byte waits, TIMEOUT stays 0; hold BF=1 permanently -> TIMEOUT=1 after 2000 us and the FSM advances.
REQ-039 Reset: assert RST while LCD_E=1 -> LCD_E=0 next clk, READY=0, FIFO empty, power-up restarts.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, command bytes and power-up timing for the LCD text driver
package lcd_pkg;
  typedef enum logic [3:0] {
    PWR_WAIT, PWR_STROBE, CFG, IDLE, FETCH, SETUP, E_HI, E_LO,
    POLL_SETUP, POLL_E_HI, POLL_SAMPLE, POLL_E_LO, WRAP
  } lcd_state_t;
  localparam logic [7:0] CMD_FUNC  = 8'h3C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [7:0] ROW0_BASE = 8'h00;
  localparam logic [7:0] ROW1_BASE = 8'h40;
  localparam logic [13:0] PWR_WAIT0 = 14'd15000;
  localparam logic [13:0] PWR_WAIT1 = 14'd4500;
  localparam logic [13:0] PWR_WAIT2 = 14'd4500;
  localparam logic [13:0] PWR_WAIT3 = 14'd150;
  function automatic logic [13:0] pwr_wait(input logic [1:0] i);
    return i == 2'd0 ? PWR_WAIT0 : i == 2'd1 ? PWR_WAIT1 : i == 2'd2 ? PWR_WAIT2 : PWR_WAIT3;
  endfunction
  function automatic logic [7:0] cfg_cmd(input logic [1:0] i);
    return i == 2'd0 ? CMD_FUNC : i == 2'd1 ? CMD_ENTRY : i == 2'd2 ? CMD_DISP : CMD_CLEAR;
  endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: show-ahead FIFO with registered full/empty flags
module lcd_cmd_fifo #(
  parameter int DEPTH = 32,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign cnt_n = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign dout = mem[rp];
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  end
endmodule

// File: rtl/lcd_text_driver.sv
// lcd_text_driver: HD44780-style LCD writer with power-up init, busy polling and line wrap
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int FIFO_DEPTH = 32,
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter int BUSY_TO_US = 2000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [8:0] DATA_IN,
  input  logic       BF,
  output logic       FULL,
  output logic       EMPTY,
  output logic       READY,
  output logic       OVERFLOW,
  output logic       TIMEOUT,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB
);
  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(BUSY_TO_US + 8);
  lcd_state_t state;
  logic [DW-1:0] div_cnt;
  logic [13:0] wcnt;
  logic [1:0] pidx, ph, cidx;
  logic [BW-1:0] btmr;
  logic bsy, wrap_pend, row, tick, rd_en;
  logic [5:0] col, col_inc, col_ld;
  logic [8:0] fifo_dout;
  assign tick = div_cnt == DW'(DIV - 1);
  assign rd_en = tick && state == FETCH;
  assign col_inc = col + 1'b1;
  assign col_ld = fifo_dout[5:0] > 6'(COLS - 1) ? 6'(COLS - 1) : fifo_dout[5:0];
  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk(clk),
    .RST(RST),
    .wr_en(WR_EN),
    .din(DATA_IN),
    .rd_en(rd_en),
    .dout(fifo_dout),
    .full(FULL),
    .empty(EMPTY)
  );
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= PWR_WAIT;
      div_cnt <= '0;
      wcnt <= PWR_WAIT0 - 14'd1;
      pidx <= '0;
      ph <= '0;
      cidx <= '0;
      btmr <= '0;
      bsy <= 1'b0;
      wrap_pend <= 1'b0;
      row <= 1'b0;
      col <= '0;
      READY <= 1'b0;
      OVERFLOW <= 1'b0;
      TIMEOUT <= 1'b0;
      LCD_E <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_RW <= 1'b0;
      LCD_DB <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (WR_EN && FULL) OVERFLOW <= 1'b1;
      if (tick) begin
        if (state inside {POLL_SETUP, POLL_E_HI, POLL_SAMPLE, POLL_E_LO}) btmr <= btmr + 1'b1;
        case (state)
          PWR_WAIT:
            if (wcnt != '0) wcnt <= wcnt - 14'd1;
            else if (pidx == 2'd3) begin
              cidx <= '0;
              state <= CFG;
            end else begin
              LCD_DB <= CMD_FUNC;
              LCD_RS <= 1'b0;
              LCD_RW <= 1'b0;
              ph <= '0;
              state <= PWR_STROBE;
            end
          PWR_STROBE: begin
            ph <= ph + 1'b1;
            LCD_E <= ph == 2'd0;
            if (ph == 2'd2) begin
              ph <= '0;
              pidx <= pidx + 2'd1;
              wcnt <= pwr_wait(pidx + 2'd1) - 14'd1;
              state <= PWR_WAIT;
            end
          end
          CFG: begin
            LCD_DB <= cfg_cmd(cidx);
            LCD_RS <= 1'b0;
            LCD_RW <= 1'b0;
            state <= SETUP;
          end
          IDLE: if (READY && !EMPTY) state <= FETCH;
          FETCH: begin
            LCD_RS <= fifo_dout[8];
            LCD_RW <= 1'b0;
            LCD_DB <= fifo_dout[7:0];
            state <= SETUP;
            if (fifo_dout[8]) begin
              col <= col_inc;
              wrap_pend <= col_inc == 6'(COLS);
            end else if (fifo_dout[7]) begin
              row <= (ROWS > 1) && fifo_dout[6];
              col <= col_ld;
            end else if (fifo_dout[7:0] == CMD_CLEAR || fifo_dout[7:0] == CMD_HOME) begin
              row <= 1'b0;
              col <= '0;
            end
          end
          SETUP: begin
            LCD_E <= 1'b1;
            state <= E_HI;
          end
          E_HI: begin
            LCD_E <= 1'b0;
            state <= E_LO;
          end
          E_LO: begin
            LCD_RW <= 1'b1;
            LCD_RS <= 1'b0;
            btmr <= '0;
            state <= POLL_SETUP;
          end
          POLL_SETUP: begin
            LCD_E <= 1'b1;
            state <= POLL_E_HI;
          end
          POLL_E_HI: state <= POLL_SAMPLE;
          POLL_SAMPLE: begin
            bsy <= BF;
            LCD_E <= 1'b0;
            state <= POLL_E_LO;
          end
          POLL_E_LO:
            if (bsy && btmr < BW'(BUSY_TO_US)) begin
              LCD_E <= 1'b1;
              state <= POLL_E_HI;
            end else begin
              // a stuck busy flag is treated as ready so the queue keeps draining
              if (bsy) TIMEOUT <= 1'b1;
              LCD_RW <= 1'b0;
              if (!READY) begin
                if (cidx == 2'd3) READY <= 1'b1;
                else cidx <= cidx + 2'd1;
                state <= cidx == 2'd3 ? IDLE : CFG;
              end else state <= wrap_pend ? WRAP : IDLE;
            end
          WRAP: begin
            row <= (ROWS > 1) ? !row : 1'b0;
            col <= '0;
            wrap_pend <= 1'b0;
            LCD_RS <= 1'b0;
            LCD_RW <= 1'b0;
            LCD_DB <= CMD_DDRAM | (((ROWS > 1) && !row) ? ROW1_BASE : ROW0_BASE);
            state <= SETUP;
          end
          default: state <= PWR_WAIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_text_driver.sv
// tb_lcd_text_driver: directed bench with a write scoreboard for lcd_text_driver
module tb_lcd_text_driver;
  timeunit 1ns;
  timeprecision 1ps;
  logic clk = 1'b0;
  logic RST, WR_EN, BF;
  logic [8:0] DATA_IN;
  logic FULL, EMPTY, READY, OVERFLOW, TIMEOUT, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DB;
  int n_chk = 0, n_fail = 0, cyc = 0, wr_count = 0, poll_count = 0;
  logic prev_e = 1'b0;
  logic [8:0] sb[$];
  int wr_cyc[$];

  lcd_text_driver #(.CLK_HZ(2_000_000)) dut (
    .clk(clk), .RST(RST), .WR_EN(WR_EN), .DATA_IN(DATA_IN), .BF(BF),
    .FULL(FULL), .EMPTY(EMPTY), .READY(READY), .OVERFLOW(OVERFLOW), .TIMEOUT(TIMEOUT),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DB(LCD_DB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // every LCD write strobe is matched against the next expected {RS,byte}
  always @(negedge clk) begin
    logic [8:0] e;
    if (!RST && LCD_E && !prev_e) begin
      if (!LCD_RW) begin
        wr_count++;
        wr_cyc.push_back(cyc);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_write", {LCD_RS, LCD_DB}, e);
        end
      end else begin
        poll_count++;
        check("poll_rs", LCD_RS, 0);
      end
    end
    prev_e = LCD_E;
  end

  task automatic push(input logic [8:0] d, input bit keep);
    WR_EN = 1'b1;
    DATA_IN = d;
    if (keep) sb.push_back(d);
    @(negedge clk);
    WR_EN = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && wr_count < n; i++) @(negedge clk);
    check(tag, wr_count, n);
  endtask

  task automatic drain(input int n, input string tag);
    wait_writes(n, 6000, tag);
    repeat (40) @(negedge clk);
    check({tag, "_sb"}, sb.size(), 0);
    check({tag, "_empty"}, EMPTY, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t, base, pc0, zc;
    RST = 1'b1; WR_EN = 1'b0; DATA_IN = '0; BF = 1'b0;
    foreach (sb[i]) sb.delete();
    repeat (3) sb.push_back({1'b0, 8'h3C});
    sb.push_back({1'b0, 8'h3C}); sb.push_back({1'b0, 8'h06});
    sb.push_back({1'b0, 8'h0C}); sb.push_back({1'b0, 8'h01});
    repeat (4) @(negedge clk);
    check("rst_e", LCD_E, 0); check("rst_rs", LCD_RS, 0); check("rst_rw", LCD_RW, 0);
    check("rst_db", LCD_DB, 0); check("rst_ready", READY, 0); check("rst_ovf", OVERFLOW, 0);
    check("rst_to", TIMEOUT, 0); check("rst_empty", EMPTY, 1); check("rst_full", FULL, 0);
    RST = 1'b0;
    rel = cyc;
    // fill during power-up: 32 characters, wrap commands after the 16th and 32nd
    for (int i = 0; i < 32; i++) begin
      push({1'b1, 8'h41 + 8'(i)}, 1'b1);
      if (i == 15) sb.push_back({1'b0, 8'hC0});
      if (i == 31) sb.push_back({1'b0, 8'h80});
      if (i == 30) check("full_at_31", FULL, 0);
    end
    check("full_at_32", FULL, 1);
    check("ovf_before", OVERFLOW, 0);
    push({1'b1, 8'h23}, 1'b0);
    check("ovf_after", OVERFLOW, 1);
    check("full_after_drop", FULL, 1);
    for (int i = 0; i < 60000 && !READY; i++) @(negedge clk);
    check("ready", READY, 1);
    check("pwr_writes", wr_count, 7);
    check("fifo_held", EMPTY, 0);
    t = (wr_cyc[0] - rel) / 2; check("pwr_t1", t >= 14980 && t <= 15020, 1);
    t = (wr_cyc[1] - rel) / 2; check("pwr_t2", t >= 19480 && t <= 19520, 1);
    t = (wr_cyc[2] - rel) / 2; check("pwr_t3", t >= 23980 && t <= 24020, 1);
    drain(41, "wrap_drain");
    check("ovf_sticky", OVERFLOW, 1);
    // cursor address loads, saturation and clear
    push({1'b0, 8'h8F}, 1'b1); push({1'b1, 8'h78}, 1'b1); sb.push_back({1'b0, 8'hC0});
    push({1'b0, 8'hD0}, 1'b1); push({1'b1, 8'h79}, 1'b1); sb.push_back({1'b0, 8'h80});
    push({1'b0, 8'hC3}, 1'b1); push({1'b0, 8'h01}, 1'b1);
    for (int i = 0; i < 16; i++) push({1'b1, 8'h61 + 8'(i)}, 1'b1);
    sb.push_back({1'b0, 8'hC0});
    drain(66, "cursor_drain");
    // busy for 300 us
    BF = 1'b1;
    push({1'b1, 8'h58}, 1'b1); push({1'b1, 8'h59}, 1'b1);
    wait_writes(67, 200, "busy_first");
    pc0 = poll_count;
    repeat (600) @(negedge clk);
    check("busy_hold", wr_count, 67);
    check("busy_repeat", (poll_count - pc0) > 50, 1);
    BF = 1'b0;
    drain(68, "busy_drain");
    check("busy_no_to", TIMEOUT, 0);
    // permanently busy
    BF = 1'b1;
    push({1'b1, 8'h5A}, 1'b1); push({1'b1, 8'h57}, 1'b1);
    wait_writes(69, 200, "to_first");
    zc = cyc;
    for (int i = 0; i < 6000 && !TIMEOUT; i++) @(negedge clk);
    check("to_set", TIMEOUT, 1);
    t = (cyc - zc) / 2;
    check("to_time", t >= 1995 && t <= 2015, 1);
    check("to_hold", wr_count, 69);
    wait_writes(70, 100, "to_advance");
    BF = 1'b0;
    drain(70, "to_drain");
    // reset with E high mid-write
    push({1'b1, 8'h52}, 1'b1); push({1'b1, 8'h53}, 1'b1);
    for (int i = 0; i < 200 && !(LCD_E && !LCD_RW); i++) @(negedge clk);
    check("rst2_e_seen", LCD_E, 1);
    RST = 1'b1;
    @(negedge clk);
    check("rst2_e", LCD_E, 0); check("rst2_ready", READY, 0); check("rst2_empty", EMPTY, 1);
    check("rst2_full", FULL, 0); check("rst2_to", TIMEOUT, 0); check("rst2_ovf", OVERFLOW, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    RST = 1'b0;
    base = wr_count;
    push({1'b1, 8'h54}, 1'b0);
    check("rst2_accept", EMPTY, 0);
    repeat (4000) @(negedge clk);
    check("rst2_no_strobe", wr_count, base);
    check("rst2_not_ready", READY, 0);
    check("rst2_held", EMPTY, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
